// File: rtl/weight_s_loader_mmap_ar_arbiter.sv
// Shares one AXI4 read channel (AR + R) between NUM_REQ requesters. It routes R bursts back in order
// through a FIFO of grant indices. Define WEIGHT_S_LOADER_AR_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module weight_s_loader_mmap_ar_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int ADDR_WIDTH      = 64,
   parameter int LEN_WIDTH       = 8,
   parameter int DATA_WIDTH      = 512,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]     req_len,
   output logic                             m_ar_valid,
   input  logic                             m_ar_ready,
   output logic [ADDR_WIDTH-1:0]            m_ar_addr,
   output logic [LEN_WIDTH-1:0]             m_ar_len,
   input  logic                             m_r_valid,
   output logic                             m_r_ready,
   input  logic [DATA_WIDTH-1:0]            m_r_data,
   input  logic                             m_r_last,
   output logic [NUM_REQ-1:0]               rsp_valid,
   input  logic [NUM_REQ-1:0]               rsp_ready,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   output logic                             rsp_last
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                r_state;
   logic                  r_arValid;
   logic [ADDR_WIDTH-1:0] r_arAddr;
   logic [LEN_WIDTH-1:0]  r_arLen;
   logic [IDX_W-1:0]      r_pendIdx;
`ifndef WEIGHT_S_LOADER_AR_ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0]      r_lastGrant;
`endif
   logic [IDX_W-1:0]      r_route [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      r_wrPtr;
   logic [PTR_W-1:0]      r_rdPtr;
   logic [CNT_W-1:0]      r_count;

   logic [IDX_W-1:0]      w_winner;
   logic                  w_anyValid;
   logic                  w_grant;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_nonEmpty;
   logic [IDX_W-1:0]      w_head;

`ifdef WEIGHT_S_LOADER_AR_ARB_FIXED_PRIO_EN
   // Descending scan so the lowest-index valid requester is written last and wins.
   always_comb begin
      w_winner   = '0;
      w_anyValid = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[k]) begin
            w_winner   = IDX_W'(k);
            w_anyValid = 1'b1;
         end
      end
   end
`else
   // Offset 1 past the last grant has top priority, so scan offsets from farthest to nearest.
   always_comb begin
      int idx;
      idx        = 0;
      w_winner   = '0;
      w_anyValid = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(r_lastGrant) + k) % NUM_REQ;
         if (req_valid[idx]) begin
            w_winner   = IDX_W'(idx);
            w_anyValid = 1'b1;
         end
      end
   end
`endif

   assign w_grant    = (r_state == IDLE) && w_anyValid && (r_count < FULL_CNT) && !reset;
   assign req_ready  = w_grant ? (NUM_REQ'(1) << w_winner) : '0;
   assign w_push     = r_arValid && m_ar_ready;
   assign w_nonEmpty = (r_count != '0) && !reset;
   assign w_head     = r_route[r_rdPtr];
   assign rsp_valid  = w_nonEmpty ? (NUM_REQ'(m_r_valid) << w_head) : '0;
   assign m_r_ready  = w_nonEmpty && rsp_ready[w_head];
   assign w_pop      = m_r_valid && m_r_ready && m_r_last;
   assign rsp_data   = m_r_data;
   assign rsp_last   = m_r_last;
   assign m_ar_valid = r_arValid;
   assign m_ar_addr  = r_arAddr;
   assign m_ar_len   = r_arLen;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_arValid   <= 1'b0;
         r_arAddr    <= '0;
         r_arLen     <= '0;
         r_pendIdx   <= '0;
`ifndef WEIGHT_S_LOADER_AR_ARB_FIXED_PRIO_EN
         r_lastGrant <= IDX_W'(NUM_REQ - 1);
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_arAddr  <= req_addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
                  r_arLen   <= req_len[int'(w_winner)*LEN_WIDTH +: LEN_WIDTH];
                  r_pendIdx <= w_winner;
                  r_arValid <= 1'b1;
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_ar_ready) begin
`ifndef WEIGHT_S_LOADER_AR_ARB_FIXED_PRIO_EN
                  r_lastGrant <= r_pendIdx;
`endif
                  r_arValid   <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Route FIFO: one entry per issued AR, retired when its R burst ends.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_route[r_wrPtr] <= r_pendIdx;
            r_wrPtr          <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_s_loader_mmap_ar_arbiter.sv
// Directed testbench for weight_s_loader_mmap_ar_arbiter; AR and R traffic are checked against
// scoreboard queues filled by the stimulus.
module tb_weight_s_loader_mmap_ar_arbiter;

   localparam int NR = 2;
   localparam int AW = 64;
   localparam int LW = 8;
   localparam int DW = 32;
   localparam int MO = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*AW-1:0] req_addr;
   logic [NR*LW-1:0] req_len;
   logic             m_ar_valid;
   logic             m_ar_ready;
   logic [AW-1:0]    m_ar_addr;
   logic [LW-1:0]    m_ar_len;
   logic             m_r_valid;
   logic             m_r_ready;
   logic [DW-1:0]    m_r_data;
   logic             m_r_last;
   logic [NR-1:0]    rsp_valid;
   logic [NR-1:0]    rsp_ready;
   logic [DW-1:0]    rsp_data;
   logic             rsp_last;

   always #5 clk = ~clk;

   weight_s_loader_mmap_ar_arbiter #(
      .NUM_REQ(NR), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_last(m_r_last),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last)
   );

   typedef struct { int owner; logic [AW-1:0] addr; logic [LW-1:0] len; } arExp_t;
   typedef struct { logic [NR-1:0] valid; logic [DW-1:0] data; logic last; } rspExp_t;

   arExp_t        arQ[$];
   rspExp_t       rspQ[$];
   int            ownerQ[$];
   int            lenQ[$];
   int            arCycles[$];
   int            vectors = 0;
   int            miscompares = 0;
   int            cycleNum = 0;
   logic [AW-1:0] base[NR];
   int            reqCnt[NR];
   logic [LW-1:0] lenOf[NR];
   logic [NR-1:0] accepted;
   logic [AW-1:0] expAddr;
   int            head;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [NR-1:0] valid, input logic arReady, input logic [NR-1:0] rspRdy);
      req_valid  = valid;
      m_ar_ready = arReady;
      rsp_ready  = rspRdy;
   endtask

   // Each requester walks its own address stream, advancing by 0x100 per accepted request.
   task automatic updateAddrs();
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW] = base[i] + 64'(reqCnt[i]) * 64'h100;
         req_len[i*LW +: LW]  = lenOf[i];
      end
   endtask

   task automatic monitor();
      arExp_t  a;
      rspExp_t r;
      accepted = req_valid & req_ready;
      if (m_ar_valid && m_ar_ready) begin
         if (arQ.size() == 0) checkOutput("ar_unexpected", 64'(m_ar_valid), 64'd0);
         else begin
            a = arQ.pop_front();
            checkOutput("ar_addr", m_ar_addr, a.addr);
            checkOutput("ar_len", 64'(m_ar_len), 64'(a.len));
            ownerQ.push_back(a.owner);
            lenQ.push_back(int'(a.len));
            arCycles.push_back(cycleNum);
         end
      end
      if (m_r_valid && m_r_ready) begin
         if (rspQ.size() == 0) checkOutput("r_unexpected", 64'(m_r_ready), 64'd0);
         else begin
            r = rspQ.pop_front();
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(r.valid));
            checkOutput("rsp_data", 64'(rsp_data), 64'(r.data));
            checkOutput("rsp_last", 64'(rsp_last), 64'(r.last));
         end
      end
   endtask

   task automatic cycle();
      #1;
      monitor();
      @(posedge clk);
      #1;
      cycleNum++;
      for (int i = 0; i < NR; i++) if (accepted[i]) reqCnt[i]++;
      updateAddrs();
   endtask

   task automatic sendBurst(input logic [NR-1:0] rdy);
      int      owner;
      int      len;
      int      waitCnt;
      rspExp_t r;
      if (ownerQ.size() == 0) return;
      owner = ownerQ.pop_front();
      len   = lenQ.pop_front();
      for (int b = 0; b <= len; b++) begin
         r.valid   = NR'(1) << owner;
         r.data    = $urandom;
         r.last    = (b == len);
         m_r_valid = 1'b1;
         m_r_data  = r.data;
         m_r_last  = r.last;
         rsp_ready = rdy;
         rspQ.push_back(r);
         waitCnt = 0;
         while (rspQ.size() != 0 && waitCnt < 8) begin
            cycle();
            waitCnt++;
         end
         checkOutput("r_beat_timeout", 64'(rspQ.size()), 64'd0);
         rspQ.delete();
      end
      m_r_valid = 1'b0;
      m_r_last  = 1'b0;
   endtask

   task automatic resetDut();
      reset = 1'b1;
      applyStimulus('0, 1'b0, '0);
      m_r_valid = 1'b0;
      m_r_last  = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      arQ.delete(); rspQ.delete(); ownerQ.delete(); lenQ.delete(); arCycles.delete();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      reset    = 1'b1;
      m_r_data = '0;
      m_r_last = 1'b0;
      base[0] = 64'h1000; base[1] = 64'h3000;
      lenOf[0] = 8'd3;    lenOf[1] = 8'd1;
      reqCnt[0] = 0;      reqCnt[1] = 0;
      updateAddrs();
      applyStimulus(2'b11, 1'b0, 2'b11);
      m_r_valid = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      #1;
      checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
      checkOutput("reset_ar_valid", 64'(m_ar_valid), 64'd0);
      checkOutput("reset_ar_addr", m_ar_addr, 64'd0);
      checkOutput("reset_ar_len", 64'(m_ar_len), 64'd0);
      checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset_r_ready", 64'(m_r_ready), 64'd0);

      // Single request from requester 0, burst of 4 beats.
      reset = 1'b0;
      m_r_valid = 1'b0;
      arQ.push_back('{0, 64'h1000, 8'd3});
      applyStimulus(2'b01, 1'b1, 2'b11);
      #1;
      checkOutput("single_req_ready", 64'(req_ready), 64'd1);
      cycle();
      applyStimulus(2'b00, 1'b1, 2'b11);
      #1;
      checkOutput("single_ar_valid", 64'(m_ar_valid), 64'd1);
      checkOutput("single_ar_addr", m_ar_addr, 64'h1000);
      checkOutput("single_ar_len", 64'(m_ar_len), 64'd3);
      checkOutput("single_busy_ready", 64'(req_ready), 64'd0);
      cycle();
      checkOutput("single_ar_done", 64'(arQ.size()), 64'd0);
      sendBurst(2'b11);
      m_r_valid = 1'b1;
      #1;
      checkOutput("empty_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("empty_r_ready", 64'(m_r_ready), 64'd0);
      m_r_valid = 1'b0;

      // Contention until the route FIFO is full, with no R traffic.
      resetDut();
      base[0] = 64'h2000; base[1] = 64'h3000;
      lenOf[0] = 8'd0;    lenOf[1] = 8'd1;
      reqCnt[0] = 0;      reqCnt[1] = 0;
      updateAddrs();
`ifdef WEIGHT_S_LOADER_AR_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 4; k++) arQ.push_back('{0, 64'h2000 + 64'(k) * 64'h100, 8'd0});
`else
      arQ.push_back('{0, 64'h2000, 8'd0});
      arQ.push_back('{1, 64'h3000, 8'd1});
      arQ.push_back('{0, 64'h2100, 8'd0});
      arQ.push_back('{1, 64'h3100, 8'd1});
`endif
      applyStimulus(2'b11, 1'b1, 2'b11);
      n = 0;
      while (arQ.size() != 0 && n < 20) begin
         cycle();
         n++;
      end
      checkOutput("contention_ar_timeout", 64'(arQ.size()), 64'd0);
      for (int i = 1; i < arCycles.size(); i++)
         checkOutput("ar_spacing", 64'(arCycles[i] - arCycles[i-1]), 64'd2);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("full_req_ready", 64'(req_ready), 64'd0);
         cycle();
      end

      // Pop the head burst: grant is blocked in the pop cycle, allowed in the next.
      rspQ.push_back('{2'b01, 32'h0bad_cafe, 1'b1});
      void'(ownerQ.pop_front());
      void'(lenQ.pop_front());
      m_r_valid = 1'b1;
      m_r_data  = 32'h0bad_cafe;
      m_r_last  = 1'b1;
      #1;
      checkOutput("full_pop_cycle_ready", 64'(req_ready), 64'd0);
      cycle();
      m_r_valid = 1'b0;
      m_r_last  = 1'b0;
      #1;
      checkOutput("pop_beat_taken", 64'(rspQ.size()), 64'd0);
      checkOutput("grant_after_pop", 64'(req_ready), 64'd1);
      applyStimulus(2'b00, 1'b1, 2'b11);

      // Head requester stalls; nothing behind it may be steered.
      head = ownerQ[0];
      m_r_valid = 1'b1;
      m_r_data  = 32'haaaa_5555;
      m_r_last  = 1'b0;
      rsp_ready = ~(NR'(1) << head);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("blocked_rsp_valid", 64'(rsp_valid), 64'(NR'(1) << head));
         checkOutput("blocked_r_ready", 64'(m_r_ready), 64'd0);
         checkOutput("blocked_rsp_data", 64'(rsp_data), 64'haaaa_5555);
         cycle();
      end
      while (ownerQ.size() != 0) sendBurst(2'b11);
      m_r_valid = 1'b1;
      #1;
      checkOutput("drained_r_ready", 64'(m_r_ready), 64'd0);
      m_r_valid = 1'b0;

      // AR backpressure on requester 1.
      expAddr = base[1] + 64'(reqCnt[1]) * 64'h100;
      arQ.push_back('{1, expAddr, lenOf[1]});
      applyStimulus(2'b10, 1'b0, 2'b11);
      #1;
      checkOutput("bp_req_ready", 64'(req_ready), 64'd2);
      cycle();
      applyStimulus(2'b11, 1'b0, 2'b11);
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("bp_ar_valid", 64'(m_ar_valid), 64'd1);
         checkOutput("bp_ar_addr", m_ar_addr, expAddr);
         checkOutput("bp_ar_len", 64'(m_ar_len), 64'(lenOf[1]));
         checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
         cycle();
      end
      applyStimulus(2'b00, 1'b1, 2'b11);
      cycle();
      #1;
      checkOutput("bp_ar_released", 64'(m_ar_valid), 64'd0);
      checkOutput("bp_ar_done", 64'(arQ.size()), 64'd0);

      // Second outstanding AR, then a third held in ISSUE when reset hits.
      arQ.push_back('{0, base[0] + 64'(reqCnt[0]) * 64'h100, lenOf[0]});
      applyStimulus(2'b01, 1'b1, 2'b11);
      cycle();
      applyStimulus(2'b00, 1'b1, 2'b11);
      cycle();
      checkOutput("second_ar_done", 64'(arQ.size()), 64'd0);
      applyStimulus(2'b01, 1'b0, 2'b11);
      cycle();
      applyStimulus(2'b00, 1'b0, 2'b11);
      #1;
      checkOutput("issue_before_reset", 64'(m_ar_valid), 64'd1);
      reset = 1'b1;
      m_r_valid = 1'b1;
      applyStimulus(2'b11, 1'b0, 2'b11);
      #1;
      checkOutput("in_reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("in_reset_r_ready", 64'(m_r_ready), 64'd0);
      checkOutput("in_reset_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("post_reset_ar_valid", 64'(m_ar_valid), 64'd0);
      checkOutput("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("post_reset_r_ready", 64'(m_r_ready), 64'd0);
      checkOutput("post_reset_req_ready", 64'(req_ready), 64'd1);
      ownerQ.delete(); lenQ.delete();
      m_r_valid = 1'b0;
      applyStimulus(2'b00, 1'b0, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
